// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. On an accepted start the operands and carry-in are
// latched, then one bit per clock (LSB first) is pushed through a single
// fulladder cell. The carry is held in a flip-flop between bit steps.
// After WIDTH bit steps the WIDTH-bit sum and the carry-out are
// registered, and done pulses for one cycle.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous active-high reset
//   start  in   1      begin an addition (accepted in IDLE or DONE)
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   cin    in   1      carry-in for bit 0, sampled on the accepting edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when sum/cout are valid
//   sum    out  WIDTH  registered result (a + b + cin) mod 2^WIDTH
//   cout   out  1      registered carry-out of bit WIDTH-1
//
// Also contains the fulladder cell used by the sequencer.
// ----------------------------------------------------------------------------

// Single-bit full adder cell: sum = x ^ y ^ cin, cout = majority(x, y, cin).
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] s_sh_q;
  logic [WIDTH-1:0] s_sh_d;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic fa_sum;
  logic fa_cout;

  fulladder fa (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 has reached the LSB.
  assign s_sh_d = {fa_sum, s_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        // start is deliberately not looked at here.
        SHIFT: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= s_sh_d;
          carry_q <= fa_cout;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) begin
            sum_q   <= s_sh_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        // Accepting start here gives back-to-back operation every WIDTH+1 cycles.
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  logic fx, fy, fc, fs, fco;

  int n_checks = 0;
  int n_err    = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  fulladder fa_ref (.x(fx), .y(fy), .cin(fc), .sum(fs), .cout(fco));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation with busy-length, done and result checks.
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic [7:0] es, input logic ec);
    int nb;
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    nb = 0;
    while (busy && nb < 20) begin
      @(posedge clk); #1;
      nb++;
    end
    check({tag, " busy_cycles"}, 32'(nb), 32'd8);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    @(posedge clk); #1;
    check({tag, " done_fall"}, 32'(done), 32'd0);
  endtask

  logic [1:0] fa_tab [8];
  logic [7:0] oa [3];
  logic [7:0] ob [3];
  logic       oc [3];
  logic [7:0] es [3];
  logic       ec [3];

  initial begin
    int nd, k, last, cnt;
    logic [7:0] got;

    fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    oa = '{8'h11, 8'h80, 8'hA5};
    ob = '{8'h22, 8'h80, 8'h5A};
    oc = '{1'b0, 1'b1, 1'b1};
    es = '{8'h33, 8'h01, 8'h00};
    ec = '{1'b0, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    fx = 1'b0; fy = 1'b0; fc = 1'b0;

    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full-adder cell truth table (index = {x,y,cin}, entry = {cout,sum}).
    for (int i = 0; i < 8; i++) begin
      {fx, fy, fc} = 3'(i);
      #1;
      check($sformatf("fa_row%0d", i), 32'({fco, fs}), 32'(fa_tab[i]));
    end

    run8("5A+3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run8("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // start re-pulsed and operands changed mid-operation must be ignored.
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; got = '0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (done) begin nd++; got = sum; end
    end
    check("repulse done_count", 32'(nd), 32'd1);
    check("repulse sum", 32'(got), 32'h47);

    // Asynchronous reset in cycle 4 of an operation.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    reset = 1'b1;
    #1;
    check("async_rst sum", 32'(sum), 32'd0);
    check("async_rst cout", 32'(cout), 32'd0);
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("aborted no_done", 32'(nd), 32'd0);
    run8("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // Exhaustive WIDTH=2.
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
          @(posedge clk); #1;
          start2 = 1'b0;
          cnt = 0;
          while (!done2 && cnt < 6) begin
            @(posedge clk); #1;
            cnt++;
          end
          check($sformatf("w2 %0d+%0d+%0d", ia, ib, ic), 32'({cout2, sum2}),
                32'(ia + ib + ic));
        end
      end
    end
    @(posedge clk); #1;

    // start held high: one result every 9 cycles, sum holding in between.
    k = 0; last = 0;
    a = oa[0]; b = ob[0]; cin = oc[0]; start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (k < 3) begin
          check($sformatf("b2b%0d sum", k), 32'(sum), 32'(es[k]));
          check($sformatf("b2b%0d cout", k), 32'(cout), 32'(ec[k]));
          if (k > 0) check($sformatf("b2b%0d interval", k), 32'(cyc - last), 32'd9);
        end
        last = cyc;
        k++;
        if (k < 3) begin
          a = oa[k]; b = ob[k]; cin = oc[k];
        end else begin
          start = 1'b0;
        end
      end else if (k > 0 && k <= 3) begin
        check("b2b hold", 32'(sum), 32'(es[k-1]));
      end
    end
    start = 1'b0;
    check("b2b done_count", 32'(k), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder for operands of WIDTH bits. It accepts two operands and a carry-in on a start pulse, then drives the existing `fulladder` cell one bit per clock, LSB first, holding the carry in a flip-flop. It returns the WIDTH-bit sum and the carry-out with a one-cycle `done` pulse. It is the sequencing stage directly upstream of `fulladder`: it generates the `x`, `y` and `cin` inputs every cycle and consumes `sum` and `cout`.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to begin an addition; sampled on the rising edge.
- a  in  WIDTH  operand A; sampled only on the edge that accepts `start`.
- b  in  WIDTH  operand B; sampled only on the edge that accepts `start`.
- cin  in  1  carry-in for bit 0; sampled together with `a` and `b`.
- busy  out  1  high while bits are being processed (SHIFT state).
- done  out  1  high for exactly one cycle when the result is valid (DONE state).
- sum  out  WIDTH  registered result A + B + cin, modulo 2^WIDTH.
- cout  out  1  registered carry-out of bit WIDTH-1.

## Operation
- One `fulladder` instance, with ports x, y, cin, sum and cout:
  - x = a_sh[0], y = b_sh[0], cin = carry flip-flop.
- Internal state:
  - shift registers a_sh, b_sh and s_sh, each WIDTH bits;
  - carry flip-flop;
  - bit counter of ceil(log2(WIDTH)) bits;
  - 2-bit FSM.
- IDLE:
  - busy=0, done=0.
  - On start=1: a_sh←a, b_sh←b, carry←cin, count←0, go to SHIFT.
- SHIFT (busy=1), each edge:
  - a_sh←a_sh>>1, b_sh←b_sh>>1.
  - s_sh←{fa.sum, s_sh[WIDTH-1:1]}.
  - carry←fa.cout, count←count+1.
  - On the edge where count==WIDTH-1, additionally:
    - sum←{fa.sum, s_sh[WIDTH-1:1]};
    - cout←fa.cout;
    - go to DONE.
- DONE:
  - done=1, busy=0.
  - Next edge: if start=1, behave exactly as the IDLE accept (load operands, go to SHIFT); otherwise go to IDLE.
- Input qualification:
  - start is ignored in SHIFT.
  - a, b and cin may change freely after the accepting edge without affecting the operation in progress.
- Output hold: `sum` and `cout` change only on the final SHIFT edge or on reset. They hold the last result through IDLE and through the whole next operation.
- Arithmetic: {cout, sum} = a + b + cin, computed at (WIDTH+1)-bit width. No overflow flag.
- Reset (asynchronous, any state, including mid-operation):
  - FSM→IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - all shift registers, carry and count cleared;
  - an aborted operation never produces `done`.
- The FSM's unused encoding returns to IDLE.

## Timing
- Let edge E0 be the edge that accepts start.
- busy is high from E0 to E_WIDTH: WIDTH cycles.
- sum and cout update, and done rises, at edge E_WIDTH. done falls at E_WIDTH+1.
- Latency from the accepting edge to done: WIDTH cycles.
- Back-to-back: start held high in the DONE cycle is accepted at E_WIDTH+1. Sustained throughput is one result per WIDTH+1 cycles.
- busy and done are never high together. Both are registered outputs, with no combinational path from inputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start -> busy high for exactly 8 cycles, then done for 1 cycle with sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple). a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Exhaustive check at WIDTH=2: all 32 combinations of a, b and cin -> {cout,sum} equals a+b+cin. Also check each bit step against the 8-row full-adder truth table.
- start re-pulsed and a/b changed during SHIFT -> ignored; the result still matches the originally latched operands, and done occurs once.
- Reset asserted at cycle 4 of an 8-bit operation (a=0x0F, b=0x01) -> outputs go to 0 immediately (asynchronously), no done appears. A later start with a=0x0F, b=0x01 -> sum=0x10, cout=0.
- start held high continuously with new operands each acceptance -> a done pulse every 9 cycles, each result correct, and sum holds between results.
